// File: rtl/bank_rd_return_mux_if.sv
// bank_rd_return_mux_if: read-request / bank-data / return bundle for bank_rd_return_mux
//   rd_en, bank_sel, bank_data : request side and bank outputs (driven by master)
//   rd_data, rd_valid, sel_err : routed return channel (driven by slave)
//   pending                    : requests in flight (driven by slave)
interface bank_rd_return_mux_if #(
   parameter int DATA_WIDTH   = 8,
   parameter int NUM_BANKS    = 4,
   parameter int SEL_WIDTH    = $clog2(NUM_BANKS),
   parameter int READ_LATENCY = 2,
   parameter int CNT_WIDTH    = $clog2(READ_LATENCY + 2)
);
   logic                            rd_en;
   logic [SEL_WIDTH-1:0]            bank_sel;
   logic [NUM_BANKS*DATA_WIDTH-1:0] bank_data;
   logic [DATA_WIDTH-1:0]           rd_data;
   logic                            rd_valid;
   logic                            sel_err;
   logic [CNT_WIDTH-1:0]            pending;
   modport master (output rd_en, bank_sel, bank_data, input rd_data, rd_valid, sel_err, pending);
   modport slave  (input rd_en, bank_sel, bank_data, output rd_data, rd_valid, sel_err, pending);
endinterface

// File: rtl/bank_rd_return_mux.sv
// bank_rd_return_mux: steers banked read data onto one return channel using a delayed select pipeline
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : bank_rd_return_mux_if.slave (request, bank data, return, pending count)
//   RD_RET_OUT_REG_EN : when defined, the return channel is registered (latency READ_LATENCY+1)
module bank_rd_return_mux #(
   parameter int DATA_WIDTH   = 8,
   parameter int NUM_BANKS    = 4,
   parameter int SEL_WIDTH    = $clog2(NUM_BANKS),
   parameter int READ_LATENCY = 2,
   parameter int CNT_WIDTH    = $clog2(READ_LATENCY + 2)
) (
   input logic i_clk,
   input logic i_rst_n,
   bank_rd_return_mux_if.slave bus
);
   logic [READ_LATENCY-1:0] vld_q, vld_d;
   logic [SEL_WIDTH-1:0]    sel_q [READ_LATENCY];
   logic [SEL_WIDTH-1:0]    sel_d [READ_LATENCY];
   logic [DATA_WIDTH-1:0]   hold_q, hold_d;
   logic [CNT_WIDTH-1:0]    pending_q, pending_d;
   logic                    tail_vld, hit, out_valid;
   logic [SEL_WIDTH-1:0]    tail_sel;
   logic [DATA_WIDTH-1:0]   ret_data;
   always_comb begin
      vld_d[0] = bus.rd_en;
      sel_d[0] = bus.rd_en ? bus.bank_sel : '0;
      for (int k = 1; k < READ_LATENCY; k++) begin
         vld_d[k] = vld_q[k-1];
         sel_d[k] = sel_q[k-1];
      end
   end
   // An unmatched select (>= NUM_BANKS) leaves hit=0 and ret_data=0.
   always_comb begin
      tail_vld = vld_q[READ_LATENCY-1];
      tail_sel = sel_q[READ_LATENCY-1];
      hit      = 1'b0;
      ret_data = '0;
      for (int b = 0; b < NUM_BANKS; b++)
         if (tail_sel == SEL_WIDTH'(b)) begin
            hit      = 1'b1;
            ret_data = bus.bank_data[b*DATA_WIDTH +: DATA_WIDTH];
         end
      hold_d    = tail_vld ? ret_data : hold_q;
      pending_d = pending_q + CNT_WIDTH'(bus.rd_en) - CNT_WIDTH'(out_valid);
   end
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         vld_q     <= '0;
         sel_q     <= '{default: '0};
         hold_q    <= '0;
         pending_q <= '0;
      end else begin
         vld_q     <= vld_d;
         sel_q     <= sel_d;
         hold_q    <= hold_d;
         pending_q <= pending_d;
      end
`ifdef RD_RET_OUT_REG_EN
   // The hold register doubles as the registered output data.
   logic vld_o_q, vld_o_d, err_o_q, err_o_d;
   always_comb begin
      vld_o_d = tail_vld;
      err_o_d = tail_vld & ~hit;
   end
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         vld_o_q <= 1'b0;
         err_o_q <= 1'b0;
      end else begin
         vld_o_q <= vld_o_d;
         err_o_q <= err_o_d;
      end
   assign out_valid    = vld_o_q;
   assign bus.rd_data  = hold_q;
   assign bus.rd_valid = vld_o_q;
   assign bus.sel_err  = err_o_q;
`else
   assign out_valid    = tail_vld;
   assign bus.rd_data  = tail_vld ? ret_data : hold_q;
   assign bus.rd_valid = tail_vld;
   assign bus.sel_err  = tail_vld & ~hit;
`endif
   assign bus.pending = pending_q;
endmodule

// File: tb/tb_bank_rd_return_mux.sv
// tb_bank_rd_return_mux: scoreboard bench driving a 4-bank and a 3-bank instance with identical requests
module tb_bank_rd_return_mux;
   localparam int RL = 2;
`ifdef RD_RET_OUT_REG_EN
   localparam int LAT = RL + 1;
`else
   localparam int LAT = RL;
`endif
   typedef struct {
      int         cyc;
      logic [7:0] d4;
      logic [7:0] d3;
      logic       e3;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rd_en = 1'b0;
   logic [1:0]  bank_sel = '0;
   logic [31:0] bank_data = '0;
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;
   int          maxp = 0;
   logic [7:0]  last4 = '0;
   logic [7:0]  last3 = '0;
   exp_t        q[$];
   bank_rd_return_mux_if #(.DATA_WIDTH(8), .NUM_BANKS(4), .READ_LATENCY(RL)) if4 ();
   bank_rd_return_mux_if #(.DATA_WIDTH(8), .NUM_BANKS(3), .READ_LATENCY(RL)) if3 ();
   assign if4.rd_en     = rd_en;
   assign if4.bank_sel  = bank_sel;
   assign if4.bank_data = bank_data;
   assign if3.rd_en     = rd_en;
   assign if3.bank_sel  = bank_sel;
   assign if3.bank_data = bank_data[23:0];
   bank_rd_return_mux #(.DATA_WIDTH(8), .NUM_BANKS(4), .READ_LATENCY(RL)) dut4 (
      .i_clk(clk), .i_rst_n(rst_n), .bus(if4.slave));
   bank_rd_return_mux #(.DATA_WIDTH(8), .NUM_BANKS(3), .READ_LATENCY(RL)) dut3 (
      .i_clk(clk), .i_rst_n(rst_n), .bus(if3.slave));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask
   task automatic chk_zero();
      chk("rst_valid4", 8'(if4.rd_valid), 8'h0);
      chk("rst_data4", if4.rd_data, 8'h0);
      chk("rst_err4", 8'(if4.sel_err), 8'h0);
      chk("rst_pend4", 8'(if4.pending), 8'h0);
      chk("rst_valid3", 8'(if3.rd_valid), 8'h0);
      chk("rst_data3", if3.rd_data, 8'h0);
      chk("rst_pend3", 8'(if3.pending), 8'h0);
   endtask
   task automatic step(input logic en, input logic [1:0] sel);
      logic [7:0] d;
      rd_en    = en;
      bank_sel = sel;
      d = bank_data[sel*8 +: 8];
      if (en) q.push_back('{cyc, d, (sel == 2'd3) ? 8'h00 : d, sel == 2'd3});
      @(posedge clk);
      #1;
   endtask
   always @(negedge clk) begin : mon
      exp_t e;
      int   n;
      logic due;
      if (rst_n) begin
         n = 0;
         foreach (q[i]) if (q[i].cyc < cyc) n++;
         due = q.size() > 0 && q[0].cyc + LAT == cyc;
         chk("pending4", 8'(if4.pending), 8'(n));
         chk("pending3", 8'(if3.pending), 8'(n));
         if (int'(if4.pending) > maxp) maxp = int'(if4.pending);
         chk("valid4", 8'(if4.rd_valid), 8'(due));
         chk("valid3", 8'(if3.rd_valid), 8'(due));
         e.e3 = 1'b0;
         if (due) begin
            e = q.pop_front();
            last4 = e.d4;
            last3 = e.d3;
         end
         chk("data4", if4.rd_data, last4);
         chk("data3", if3.rd_data, last3);
         chk("err4", 8'(if4.sel_err), 8'h0);
         chk("err3", 8'(if3.sel_err), 8'(due & e.e3));
      end
   end
   initial begin
      #12;
      chk_zero();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(0, 0);
      bank_data = 32'h00A5_0000;
      step(1, 2);
      repeat (4) step(0, 0);
      bank_data = 32'h4433_2211;
      maxp = 0;
      for (int i = 0; i < 4; i++) step(1, 2'(i));
      repeat (4) step(0, 0);
      chk("peak_pending", 8'(maxp), 8'(LAT));
      step(1, 3);
      step(1, 1);
      repeat (4) step(0, 0);
      bank_data = 32'h0000_005C;
      step(1, 0);
      repeat (LAT + 1) step(0, 0);
      for (int i = 0; i < 10; i++) begin
         bank_data = $urandom;
         step(0, 0);
      end
      chk("hold_5c", if4.rd_data, 8'h5C);
      for (int i = 0; i < 8; i++) step(0, 2'($urandom_range(0, 3)));
      bank_data = 32'hC3B2_A190;
      step(1, 1);
      step(1, 3);
      rst_n = 1'b0;
      #1;
      chk_zero();
      q.delete();
      last4 = '0;
      last3 = '0;
      rd_en = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (5) step(0, 0);
      bank_data = $urandom;
      for (int i = 0; i < 40; i++) step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      repeat (6) step(0, 0);
      chk("drained", 8'(q.size()), 8'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
